// File: rtl/data_loader_seq_if.sv
// Handshake and observation bundle between a run requester and the data loader sequencer.
// master = requester side, slave = sequencer side.
`timescale 1ns/1ps
interface data_loader_seq_if #(
    parameter int CNT_W   = 8,
    parameter int EPOCH_W = 4
);
    logic               start;
    logic               abort;
    logic               stall;
    logic               coeff_only;
    logic               en_cc;
    logic               en_err;
    logic [CNT_W-1:0]   cnt;
    logic [EPOCH_W-1:0] epoch;
    logic               busy;
    logic               done;

    modport master (
        output start, abort, stall, coeff_only,
        input  en_cc, en_err, cnt, epoch, busy, done
    );

    modport slave (
        input  start, abort, stall, coeff_only,
        output en_cc, en_err, cnt, epoch, busy, done
    );
endinterface

// File: rtl/data_loader_seq.sv
// Training data-path sequencer: per epoch walks every sample index through a coefficient
// pass and (unless coeff-only) an error pass, with stall, abort and start/busy/done handshake.
`timescale 1ns/1ps
module data_loader_seq #(
    parameter int NUM_SAMPLES = 150,
    parameter int CNT_W       = 8,
    parameter int EPOCHS      = 1,
    parameter int EPOCH_W     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    data_loader_seq_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_COEFF = 3'd2,
        S_ERROR = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0]   LAST_IDX   = CNT_W'(NUM_SAMPLES - 1);
    localparam logic [EPOCH_W-1:0] LAST_EPOCH = EPOCH_W'(EPOCHS - 1);

    state_t               state_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [EPOCH_W-1:0]   epoch_r;
    logic                 mode_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 cc_ph_r;
    logic                 err_ph_r;

    logic                 adv_s;
    logic                 last_idx_s;
    logic                 last_epoch_s;

    // Advance qualifier and end-of-pass / end-of-run detection
    always_comb begin
        adv_s        = ~bus.stall;
        last_idx_s   = (cnt_r == LAST_IDX);
        last_epoch_s = (epoch_r == LAST_EPOCH);
    end

    // Sequencer FSM with its counters and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= S_IDLE;
            cnt_r    <= '0;
            epoch_r  <= '0;
            mode_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            cc_ph_r  <= 1'b0;
            err_ph_r <= 1'b0;
        end else if (bus.abort) begin
            // Abort beats stall, pass ends and a same-cycle start
            state_r  <= S_IDLE;
            cnt_r    <= '0;
            epoch_r  <= '0;
            mode_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            cc_ph_r  <= 1'b0;
            err_ph_r <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    cnt_r    <= '0;
                    epoch_r  <= '0;
                    done_r   <= 1'b0;
                    cc_ph_r  <= 1'b0;
                    err_ph_r <= 1'b0;
                    if (bus.start) begin
                        state_r <= S_LOAD;
                        mode_r  <= bus.coeff_only;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= S_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    cnt_r   <= '0;
                    epoch_r <= '0;
                    state_r <= S_COEFF;
                    cc_ph_r <= 1'b1;
                end
                S_COEFF: begin
                    if (adv_s) begin
                        if (last_idx_s) begin
                            cnt_r <= '0;
                            if (!mode_r) begin
                                state_r  <= S_ERROR;
                                cc_ph_r  <= 1'b0;
                                err_ph_r <= 1'b1;
                            end else if (last_epoch_s) begin
                                state_r <= S_DONE;
                                cc_ph_r <= 1'b0;
                                done_r  <= 1'b1;
                            end else begin
                                epoch_r <= epoch_r + EPOCH_W'(1);
                            end
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                S_ERROR: begin
                    if (adv_s) begin
                        if (last_idx_s) begin
                            cnt_r    <= '0;
                            err_ph_r <= 1'b0;
                            if (last_epoch_s) begin
                                state_r <= S_DONE;
                                done_r  <= 1'b1;
                            end else begin
                                state_r <= S_COEFF;
                                epoch_r <= epoch_r + EPOCH_W'(1);
                                cc_ph_r <= 1'b1;
                            end
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                S_DONE: begin
                    // epoch is shown through DONE and cleared on entry to IDLE
                    state_r <= S_IDLE;
                    cnt_r   <= '0;
                    epoch_r <= '0;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r  <= S_IDLE;
                    cnt_r    <= '0;
                    epoch_r  <= '0;
                    mode_r   <= 1'b0;
                    busy_r   <= 1'b0;
                    done_r   <= 1'b0;
                    cc_ph_r  <= 1'b0;
                    err_ph_r <= 1'b0;
                end
            endcase
        end
    end

    // Phase flags are registered; only the per-cycle stall gates them
    assign bus.en_cc  = cc_ph_r  & adv_s;
    assign bus.en_err = err_ph_r & adv_s;
    assign bus.cnt    = cnt_r;
    assign bus.epoch  = epoch_r;
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;

endmodule

// File: tb/tb_data_loader_seq.sv
// Randomised bench for data_loader_seq: two configurations (150x1 and 4x3) checked cycle by
// cycle against a queue of expected (phase, epoch, index) enable events.
`timescale 1ns/1ps
module tb_data_loader_seq;

    typedef struct packed {
        logic       err;
        logic [3:0] ep;
        logic [7:0] idx;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start, abort, stall, coeff_only, sel;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    data_loader_seq_if #(.CNT_W(8), .EPOCH_W(4)) ifa ();
    data_loader_seq_if #(.CNT_W(8), .EPOCH_W(4)) ifb ();

    assign ifa.start      = start & ~sel;
    assign ifa.abort      = abort;
    assign ifa.stall      = stall;
    assign ifa.coeff_only = coeff_only;
    assign ifb.start      = start & sel;
    assign ifb.abort      = abort;
    assign ifb.stall      = stall;
    assign ifb.coeff_only = coeff_only;

    data_loader_seq #(.NUM_SAMPLES(150), .CNT_W(8), .EPOCHS(1), .EPOCH_W(4)) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    data_loader_seq #(.NUM_SAMPLES(4), .CNT_W(8), .EPOCHS(3), .EPOCH_W(4)) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
    );

    // {busy, done, en_cc, en_err, epoch, cnt} of the selected instance
    logic [15:0] obs;
    assign obs = sel ? {ifb.busy, ifb.done, ifb.en_cc, ifb.en_err, ifb.epoch, ifb.cnt}
                     : {ifa.busy, ifa.done, ifa.en_cc, ifa.en_err, ifa.epoch, ifa.cnt};

    task automatic build_run(input bit s, input bit mode, output ev_t q[$]);
        int n_s  = s ? 4 : 150;
        int n_ep = s ? 3 : 1;
        q = {};
        for (int e = 0; e < n_ep; e++) begin
            for (int i = 0; i < n_s; i++) q.push_back(ev_t'{err: 1'b0, ep: 4'(e), idx: 8'(i)});
            if (!mode)
                for (int i = 0; i < n_s; i++) q.push_back(ev_t'{err: 1'b1, ep: 4'(e), idx: 8'(i)});
        end
    endtask

    task automatic test_reset();
        logic [15:0] exp = 16'h0000;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; stall = 1'b0; coeff_only = 1'b0; sel = 1'b0;
        #2;
        for (int k = 0; k < 2; k++) begin
            sel = k[0];
            #1;
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL reset sel=%0d: got %h expected %h", k, obs, exp);
            end
        end
        @(posedge clk); @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #2;
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL reset_release: got %h expected %h", obs, exp);
        end
    endtask

    task automatic issue_start(input bit mode);
        logic [15:0] exp = {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0};
        @(negedge clk);
        start = 1'b1; coeff_only = mode; stall = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        start = 1'b0; coeff_only = ~mode; stall = 1'($urandom_range(0, 1));
        #1;
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL load_cycle: got %h expected %h", obs, exp);
        end
    endtask

    // kind: 0 no stall, 1 random stall, 2 five-cycle stall on coefficient index 2
    task automatic test_sequence(input bit s, input bit mode, input int kind);
        ev_t q[$];
        ev_t head;
        int  held = 0;
        bit  st;
        int  n_ep = s ? 3 : 1;
        logic [15:0] exp;
        sel = s;
        build_run(s, mode, q);
        issue_start(mode);
        while (q.size() > 0) begin
            head = q[0];
            @(posedge clk); #1;
            case (kind)
                0:       st = 1'b0;
                1:       st = ($urandom_range(0, 3) == 0);
                default: st = (!head.err && head.ep == 4'd0 && head.idx == 8'd2 && held < 5);
            endcase
            if (st) held++;
            stall = st; start = 1'($urandom_range(0, 1)); coeff_only = 1'($urandom_range(0, 1));
            #1;
            exp = {1'b1, 1'b0, !st && !head.err, !st && head.err, head.ep, head.idx};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL seq s=%0d m=%0d k=%0d: got %h expected %h", s, mode, kind, obs, exp);
            end
            if (!st) void'(q.pop_front());
        end
        @(posedge clk); #1;
        start = 1'b0; stall = 1'($urandom_range(0, 1)); #1;
        exp = {1'b1, 1'b1, 1'b0, 1'b0, 4'(n_ep - 1), 8'd0};
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL done_cycle s=%0d m=%0d: got %h expected %h", s, mode, obs, exp);
        end
        @(posedge clk); #1;
        stall = 1'b0; #1;
        exp = 16'h0000;
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL after_done s=%0d m=%0d: got %h expected %h", s, mode, obs, exp);
        end
    endtask

    task automatic test_abort(input bit s, input bit mode, input ev_t tgt, input bit st_at);
        ev_t q[$];
        ev_t head;
        bit  hit = 1'b0;
        logic [15:0] exp;
        sel = s;
        build_run(s, mode, q);
        issue_start(mode);
        while (q.size() > 0 && !hit) begin
            head = q[0];
            @(posedge clk); #1;
            hit   = (head == tgt);
            stall = hit ? st_at : 1'b0;
            abort = hit;
            start = 1'($urandom_range(0, 1));
            #1;
            exp = {1'b1, 1'b0, !stall && !head.err, !stall && head.err, head.ep, head.idx};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL abort_walk s=%0d: got %h expected %h", s, obs, exp);
            end
            if (!hit) void'(q.pop_front());
        end
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            abort = 1'b0; start = 1'b0; stall = 1'b0; #1;
            exp = 16'h0000;
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL abort_idle s=%0d c=%0d: got %h expected %h", s, c, obs, exp);
            end
        end
    endtask

    task automatic test_idle_abort();
        logic [15:0] exp = 16'h0000;
        sel = 1'b1;
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1; #1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            start = 1'b0; abort = 1'b0; #1;
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL idle_abort c=%0d: got %h expected %h", c, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] exp = 16'h0000;
        sel = 1'b0;
        issue_start(1'b0);
        repeat (20) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL reset_mid: got %h expected %h", obs, exp);
        end
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        test_sequence(1'b0, 1'b0, 1);
    endtask

    initial begin
        test_reset();
        test_sequence(1'b0, 1'b0, 0);
        test_sequence(1'b1, 1'b0, 0);
        test_sequence(1'b0, 1'b0, 2);
        test_sequence(1'b1, 1'b1, 1);
        test_sequence(1'b1, 1'b0, 1);
        test_sequence(1'b0, 1'b1, 0);
        test_abort(1'b0, 1'b0, ev_t'{err: 1'b1, ep: 4'd0, idx: 8'd149}, 1'b0);
        test_abort(1'b1, 1'b0, ev_t'{err: 1'b0, ep: 4'd1, idx: 8'd1}, 1'b1);
        test_abort(1'b1, 1'b1, ev_t'{err: 1'b0, ep: 4'd2, idx: 8'd3}, 1'b0);
        test_idle_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
